// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - request, divider and response signal bundle for div_issue_ctrl
interface div_issue_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [DATA_WIDTH-1:0] req_dividend;
    logic [DATA_WIDTH-1:0] req_divisor;
    logic [TAG_WIDTH-1:0]  req_tag;

    logic                  div_enable;
    logic                  div_sign;
    logic [DATA_WIDTH-1:0] div_dividend;
    logic [DATA_WIDTH-1:0] div_divider;
    logic                  div_rst_n;
    logic                  div_ready;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic                  resp_special;
    logic                  busy;

    modport slave (
        input  req_valid, req_op, req_dividend, req_divisor, req_tag,
        input  div_ready, div_quotient, div_remainder, resp_ready,
        output req_ready, div_enable, div_sign, div_dividend, div_divider, div_rst_n,
        output resp_valid, resp_data, resp_tag, resp_special, busy
    );

    modport master (
        output req_valid, req_op, req_dividend, req_divisor, req_tag,
        output div_ready, div_quotient, div_remainder, resp_ready,
        input  req_ready, div_enable, div_sign, div_dividend, div_divider, div_rst_n,
        input  resp_valid, resp_data, resp_tag, resp_special, busy
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - single-outstanding issue controller for an external divider
// Optional feature macro DIV_SPECIAL_CASE_EN: divide-by-zero and signed overflow bypass the divider.
module div_issue_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int CALC_CYCLES = 4,
    parameter int TAG_WIDTH   = 5
) (
    input logic              clk,
    input logic              rst,
    div_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                state_q;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] dividend_q;
    logic [DATA_WIDTH-1:0] divisor_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  div_enable_q;
    logic                  resp_valid_q;
    logic                  resp_special_q;
    logic                  req_ready_q;
    logic                  busy_q;

    logic                  is_special;
    logic [DATA_WIDTH-1:0] special_data;

    // CALC_CYCLES describes the divider only; completion is always taken from div_ready.
    if (CALC_CYCLES < 1) begin : g_calc_cycles_descriptive
    end

`ifdef DIV_SPECIAL_CASE_EN
    localparam logic [DATA_WIDTH-1:0] MostNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic div_by_zero;
    logic sgn_overflow;

    always_comb begin
        div_by_zero  = (bus.req_divisor == '0);
        sgn_overflow = !bus.req_op[0] && (bus.req_dividend == MostNeg) && (bus.req_divisor == '1);
        is_special   = div_by_zero || sgn_overflow;
        if (div_by_zero) begin
            special_data = bus.req_op[1] ? bus.req_dividend : '1;
        end else begin
            special_data = bus.req_op[1] ? '0 : bus.req_dividend;
        end
    end
`else
    assign is_special   = 1'b0;
    assign special_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            dividend_q     <= '0;
            divisor_q      <= '0;
            tag_q          <= '0;
            resp_data_q    <= '0;
            div_enable_q   <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_special_q <= 1'b0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q           <= bus.req_op;
                        dividend_q     <= bus.req_dividend;
                        divisor_q      <= bus.req_divisor;
                        tag_q          <= bus.req_tag;
                        req_ready_q    <= 1'b0;
                        busy_q         <= 1'b1;
                        resp_special_q <= is_special;
                        if (is_special) begin
                            resp_data_q  <= special_data;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            div_enable_q <= 1'b1;
                            state_q      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    div_enable_q <= 1'b0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.div_ready) begin
                        resp_data_q  <= op_q[1] ? bus.div_remainder : bus.div_quotient;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    // req_ready rises only after the handshake edge, so no same-cycle re-accept.
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.div_enable   = div_enable_q;
    assign bus.div_sign     = !op_q[0];
    assign bus.div_dividend = dividend_q;
    assign bus.div_divider  = divisor_q;
    assign bus.div_rst_n    = !rst;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_tag     = tag_q;
    assign bus.resp_special = resp_special_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl with a behavioural divider
module tb_div_issue_ctrl;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;
`ifdef DIV_SPECIAL_CASE_EN
    localparam bit SP_EN = 1'b1;
`else
    localparam bit SP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_issue_ctrl_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

    div_issue_ctrl #(.DATA_WIDTH(32), .CALC_CYCLES(4), .TAG_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // RISC-V style division semantics, including zero divisor and signed overflow.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == MIN_NEG && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Divider stand-in: answers stub_lat cycles after the enable pulse.
    int          cnt = -1;
    int          stub_lat = 2;
    bit          stray = 1'b0;
    int          n_en = 0;
    logic        last_sign = 1'b0;
    logic [31:0] st_a = '0;
    logic [31:0] st_b = '0;

    always @(posedge clk) begin
        #2;
        bus.div_ready = 1'b0;
        if (!bus.div_rst_n) begin
            cnt = -1;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.div_quotient  = ref_result({1'b0, !last_sign}, st_a, st_b);
                    bus.div_remainder = ref_result({1'b1, !last_sign}, st_a, st_b);
                    bus.div_ready     = 1'b1;
                    cnt = -1;
                end
            end
            if (bus.div_enable) begin
                st_a      = bus.div_dividend;
                st_b      = bus.div_divider;
                last_sign = bus.div_sign;
                cnt       = stub_lat;
                n_en++;
            end
        end
        if (stray) begin
            bus.div_ready = 1'b1;
            stray = 1'b0;
        end
    end

    // Scoreboard model: one entry per accepted request, with the cycle its response is due.
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [4:0]  tag;
        logic        special;
        bit          issued;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   rst_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        cyc++;
        if (rst_prev) begin
            chk("rst_resp_valid", bus.resp_valid, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
            chk("rst_div_enable", bus.div_enable, 1'b0);
            chk("rst_resp_special", bus.resp_special, 1'b0);
            chk("rst_resp_data", bus.resp_data, 32'd0);
            chk("rst_resp_tag", bus.resp_tag, 5'd0);
            chk("rst_req_ready", bus.req_ready, 1'b1);
        end
        if (rst) begin
            q.delete();
        end else begin
            ev = (q.size() > 0) && (q[0].due >= 0) && (cyc >= q[0].due);
            chk("resp_valid", bus.resp_valid, ev);
            chk("busy_vs_ready", bus.busy, !bus.req_ready);
            if (bus.resp_valid && q.size() > 0) begin
                chk("resp_data", bus.resp_data, q[0].data);
                chk("resp_tag", bus.resp_tag, q[0].tag);
                chk("resp_special", bus.resp_special, q[0].special);
            end
            if (bus.div_enable) begin
                chk("enable_has_req", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    chk("enable_once", q[0].issued, 1'b0);
                    chk("enable_not_special", q[0].special, 1'b0);
                    chk("div_sign", bus.div_sign, !q[0].op[0]);
                    chk("div_dividend", bus.div_dividend, q[0].a);
                    chk("div_divider", bus.div_divider, q[0].b);
                    q[0].issued = 1'b1;
                end
            end else if (q.size() > 0 && q[0].issued && q[0].due < 0) begin
                chk("wait_dividend", bus.div_dividend, q[0].a);
                chk("wait_divider", bus.div_divider, q[0].b);
                if (bus.div_ready) q[0].due = cyc + 1;
            end
            if (bus.resp_valid && bus.resp_ready && q.size() > 0) void'(q.pop_front());
            if (bus.req_valid && bus.req_ready) begin
                e.op      = bus.req_op;
                e.a       = bus.req_dividend;
                e.b       = bus.req_divisor;
                e.tag     = bus.req_tag;
                e.data    = ref_result(bus.req_op, bus.req_dividend, bus.req_divisor);
                e.special = SP_EN && ((bus.req_divisor == 32'd0) ||
                            (!bus.req_op[0] && bus.req_dividend == MIN_NEG && bus.req_divisor == 32'hFFFF_FFFF));
                e.issued  = 1'b0;
                e.due     = e.special ? cyc + 1 : -1;
                q.push_back(e);
            end
        end
        rst_prev = rst;
    end

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        @(posedge clk);
        #1;
        bus.req_op       = op;
        bus.req_dividend = a;
        bus.req_divisor  = b;
        bus.req_tag      = tag;
        bus.req_valid    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
                return;
            end
        end
        chk("req_accept_timeout", 1'b1, 1'b0);
        bus.req_valid = 1'b0;
    endtask

    task automatic get_resp(input logic [31:0] exp_d, input logic [4:0] exp_tag, input int hold,
                            output int wait_cyc, output logic got_special);
        wait_cyc    = 0;
        got_special = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.resp_valid) break;
            wait_cyc++;
        end
        chk("lit_resp_valid", bus.resp_valid, 1'b1);
        chk("lit_resp_data", bus.resp_data, exp_d);
        chk("lit_resp_tag", bus.resp_tag, exp_tag);
        got_special = bus.resp_special;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) stray = 1'b1;
            @(negedge clk);
            chk("hold_resp_valid", bus.resp_valid, 1'b1);
            chk("hold_req_ready", bus.req_ready, 1'b0);
        end
        chk("lit_resp_data_after_hold", bus.resp_data, exp_d);
        chk("lit_resp_tag_after_hold", bus.resp_tag, exp_tag);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("post_resp_valid", bus.resp_valid, 1'b0);
        chk("post_req_ready", bus.req_ready, 1'b1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp_d;
        bit          sp;
        int          hold;
    } vec_t;

    vec_t vecs[9] = '{
        '{2'b00, 32'd100,        32'hFFFF_FFF9, 5'd3,  32'hFFFF_FFF2, 1'b0, 0},
        '{2'b11, 32'hFFFF_FFFF,  32'd10,        5'd4,  32'd5,         1'b0, 5},
        '{2'b01, 32'd123,        32'd0,         5'd7,  32'hFFFF_FFFF, 1'b1, 0},
        '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0,         1'b1, 2},
        '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1, 0},
        '{2'b11, 32'd17,         32'd0,         5'd11, 32'd17,        1'b1, 0},
        '{2'b01, 32'hFFFF_FFFF,  32'd2,         5'd12, 32'h7FFF_FFFF, 1'b0, 0},
        '{2'b10, 32'hFFFF_FFF9,  32'd3,         5'd31, 32'hFFFF_FFFF, 1'b0, 3},
        '{2'b00, 32'hFFFF_FF9C,  32'd7,         5'd0,  32'hFFFF_FFF2, 1'b0, 0}
    };

    initial begin
        int   n0;
        int   wc;
        logic sp;
        bus.req_valid     = 1'b0;
        bus.req_op        = 2'b00;
        bus.req_dividend  = '0;
        bus.req_divisor   = '0;
        bus.req_tag       = '0;
        bus.resp_ready    = 1'b0;
        bus.div_ready     = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("lit_reset_req_ready", bus.req_ready, 1'b1);
        chk("lit_reset_busy", bus.busy, 1'b0);

        stray = 1'b1;
        repeat (2) @(negedge clk);
        chk("lit_idle_stray_busy", bus.busy, 1'b0);
        chk("lit_idle_stray_valid", bus.resp_valid, 1'b0);

        foreach (vecs[i]) begin
            n0 = n_en;
            do_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            get_resp(vecs[i].exp_d, vecs[i].tag, vecs[i].hold, wc, sp);
            chk("lit_special", sp, vecs[i].sp && SP_EN);
            if (vecs[i].sp && SP_EN) begin
                chk("lit_special_latency", wc, 0);
                chk("lit_special_no_enable", n_en - n0, 0);
            end else begin
                chk("lit_enable_count", n_en - n0, 1);
                chk("lit_div_sign", last_sign, !vecs[i].op[0]);
            end
        end

        stub_lat = 6;
        do_req(2'b00, 32'd7, 32'd2, 5'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("lit_abort_busy", bus.busy, 1'b0);
        chk("lit_abort_valid", bus.resp_valid, 1'b0);
        chk("lit_abort_req_ready", bus.req_ready, 1'b1);
        repeat (8) @(negedge clk);
        chk("lit_abort_no_late_resp", bus.resp_valid, 1'b0);

        stub_lat = 2;
        do_req(2'b00, 32'd50, 32'd5, 5'd2);
        get_resp(32'd10, 5'd2, 0, wc, sp);
        chk("lit_after_abort_special", sp, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width.
REQ-002 Parameter CALC_CYCLES, default 4: divider iteration count; documentation only, no latency is hard-coded.
REQ-003 Parameter TAG_WIDTH, default 5: width of the opaque request tag.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request offered.
REQ-007 req_ready  output  1  request accepted when high with req_valid.
REQ-008 req_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (bit0 = unsigned, bit1 = remainder).
REQ-009 req_dividend, req_divisor  input  DATA_WIDTH  operands.
REQ-010 req_tag  input  TAG_WIDTH  returned unchanged with the response.
REQ-011 div_enable  output  1  single-cycle start pulse to the divider.
REQ-012 div_sign  output  1  signed-operation select to the divider; equals !op[0].
REQ-013 div_dividend, div_divider  output  DATA_WIDTH  operands to the divider.
REQ-014 div_ready  input  1  divider one-cycle completion pulse.
REQ-015 div_quotient  input  DATA_WIDTH  low half of the divider result.
REQ-016 div_remainder  input  DATA_WIDTH  divider remainder.
REQ-017 resp_valid  output  1  response available.
REQ-018 resp_ready  input  1  consumer accepts the response.
REQ-019 resp_data  output  DATA_WIDTH  quotient or remainder, per op.
REQ-020 resp_tag  output  TAG_WIDTH  tag of the request being answered.
REQ-021 resp_special  output  1  response was resolved by the special-case path.
REQ-022 busy  output  1  high in every state except IDLE.

Function
REQ-023 The block SHALL implement the FSM IDLE, ISSUE, WAIT, RESP, with one operation in flight at a time.
REQ-024 req_ready SHALL equal (state==IDLE); on acceptance, the op, operands and tag SHALL be registered.
REQ-025 On acceptance of a non-special request, the FSM SHALL move IDLE->ISSUE.
  - In ISSUE, div_enable=1 for exactly one cycle, with registered operands and div_sign on the divider ports; then ISSUE->WAIT.
REQ-026 In WAIT, the FSM SHALL stay until div_ready=1.
  - In that cycle, capture div_quotient if op[1]=0, otherwise div_remainder; then WAIT->RESP.
REQ-027 In RESP, resp_valid SHALL be 1 and resp_data, resp_tag and resp_special SHALL be held stable until resp_valid&&resp_ready; then RESP->IDLE.
REQ-028 A new request SHALL NOT be accepted in the cycle a response completes; the earliest next acceptance is the following cycle.
REQ-029 Latency SHALL be: resp_valid rises the cycle after div_ready is sampled (non-special), or the cycle after acceptance (special).
REQ-030 div_ready outside WAIT SHALL be ignored, with no state change and no capture.
REQ-031 div_enable SHALL be 0 in every state except ISSUE.
REQ-032 div_dividend and div_divider SHALL hold the registered operands from ISSUE through WAIT.
REQ-033 resp_valid SHALL be 0 in every state except RESP.

Reset
REQ-034 While rst=1, the following SHALL hold on the next edge:
  - state=IDLE, div_enable=0, resp_valid=0, resp_special=0;
  - resp_data=0, resp_tag=0, busy=0.
REQ-035 rst asserted mid-operation (ISSUE/WAIT/RESP) SHALL abort the operation, discard any pending response and return to IDLE.
REQ-036 The divider's active-low reset SHALL be driven from !rst, so that both blocks abort together and the divider is idle when the controller next issues.

Configuration
REQ-037 Macro DIV_SPECIAL_CASE_EN SHALL select the special-case path.
REQ-038 With DIV_SPECIAL_CASE_EN defined, special requests SHALL bypass the divider (IDLE->RESP, no div_enable) and set resp_special=1:
  - divisor==0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed op with dividend==most-negative and divisor==all-ones: DIV returns the dividend; REM returns 0.
REQ-039 Without DIV_SPECIAL_CASE_EN, every request SHALL go through the divider, resp_data SHALL be the raw divider output, and resp_special SHALL be constant 0.

Verification
REQ-040 DIV, 100 / -7, tag 3 -> exactly one div_enable pulse with div_sign=1; resp_data=0xFFFFFFF2 (-14), resp_tag=3, one cycle after div_ready.
REQ-041 REMU, 0xFFFFFFFF % 10 -> resp_data=5; div_sign=0.
REQ-042 DIV_SPECIAL_CASE_EN defined, DIVU 123 / 0 -> resp_data=0xFFFFFFFF, resp_special=1, resp_valid the cycle after acceptance, no div_enable.
  - REM 0x80000000 % 0xFFFFFFFF -> resp_data=0, resp_special=1.
REQ-043 resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_data and resp_tag stable; req_ready=0 throughout.
  - A stray div_ready pulse injected during RESP -> no change.
REQ-044 rst=1 asserted in WAIT -> next cycle state IDLE, busy=0, resp_valid=0.
  - A subsequent DIV 50 / 5 returns 10.
